// File: rtl/game_pkg.sv
// game_pkg: shared key index and debounce interval constants for the game board
package game_pkg;
  localparam int KEY_HARD = 0;
  localparam int KEY_MED = 1;
  localparam int KEY_EASY = 2;
  localparam int KEY_START = 3;
  localparam int DEBOUNCE_CYCLES_20MS = 1000000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;
endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one active-low pushbutton to a debounced active-high level with press/release strobes
module key_debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic debounced,
  output logic pressed,
  output logic released
);
  logic sync1, sync2;
  logic [CNT_W-1:0] cnt;
  logic raw_hi;
  assign raw_hi = ~sync2;
  // synchronise the pin, count consecutive disagreeing cycles, commit the new level when the count completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt <= '0;
      debounced <= 1'b0;
      pressed <= 1'b0;
      released <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      pressed <= 1'b0;
      released <= 1'b0;
      if (raw_hi == debounced) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        debounced <= raw_hi;
        cnt <= '0;
        pressed <= raw_hi;
        released <= ~raw_hi;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/key_debounce_bank.sv
// key_debounce_bank: independent debouncers for the board pushbuttons
module key_debounce_bank
  import game_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_20MS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_debounced,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_released
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  for (genvar g = 0; g < NUM_KEYS; g++) begin : ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .key_n(KEY[g]),
      .debounced(key_debounced[g]),
      .pressed(key_pressed[g]),
      .released(key_released[g])
    );
  end
endmodule
